// File: rtl/pipe_regfile_sb.sv
// Decode-stage register file with NUM_RD async read ports, one sync write port and a
// per-register in-flight scoreboard. Define RF_BYPASS_EN for same-cycle write-through.
module pipe_regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int PEND_W = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] RD,
   output logic [NUM_RD-1:0]        RPend,
   input  logic                     WE3,
   input  logic [ADDR_W-1:0]        A3,
   input  logic [DATA_W-1:0]        WD3,
   input  logic                     Retire,
   input  logic                     IssueValid,
   input  logic [ADDR_W-1:0]        IssueAddr,
   output logic                     IssueReady,
   input  logic                     Flush,
   output logic                     SbErr
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PEND_W-1:0] r_cnt [DEPTH];
   logic [PEND_W-1:0] w_cntNext [DEPTH];
   logic              r_sbErr;

   logic w_ret;
   logic w_issue;
   logic w_retHitsIssue;
   logic w_err;

   assign w_ret          = WE3 && Retire && (A3 != '0);
   assign w_retHitsIssue = w_ret && (A3 == IssueAddr);
   // A retire to the saturated register frees a slot in the same cycle.
   assign IssueReady     = !((r_cnt[IssueAddr] == CNT_MAX) && !w_retHitsIssue);
   assign w_issue        = IssueValid && IssueReady && (IssueAddr != '0) && !Flush;
   assign w_err          = w_ret && (r_cnt[A3] == '0) && !Flush;
   assign SbErr          = r_sbErr;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_mem[r] <= '0;
         end
      end else if (WE3 && (A3 != '0)) begin
         r_mem[A3] <= WD3;
      end
   end

   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         w_cntNext[r] = r_cnt[r];
         if (Flush) begin
            w_cntNext[r] = '0;
         end else if (r != 0) begin
            if (w_issue && (IssueAddr == ADDR_W'(r)) && !(w_ret && (A3 == ADDR_W'(r)))) begin
               w_cntNext[r] = r_cnt[r] + CNT_ONE;
            end else if (w_ret && (A3 == ADDR_W'(r)) &&
                         !(w_issue && (IssueAddr == ADDR_W'(r))) &&
                         (r_cnt[r] != '0)) begin
               w_cntNext[r] = r_cnt[r] - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            r_cnt[r] <= w_cntNext[r];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sbErr <= 1'b0;
      end else if (w_err) begin
         r_sbErr <= 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = RA[p*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      logic w_hit;
      assign w_hit = WE3 && (A3 == w_ra);
      assign RD[p*DATA_W +: DATA_W] = (w_ra == '0) ? '0 : (w_hit ? WD3 : r_mem[w_ra]);
      // Final retire forwards its data now, so the pending flag drops a cycle early.
      assign RPend[p] = (r_cnt[w_ra] != '0) &&
                        !(w_ret && (A3 == w_ra) && (r_cnt[w_ra] == CNT_ONE));
`else
      assign RD[p*DATA_W +: DATA_W] = (w_ra == '0) ? '0 : r_mem[w_ra];
      assign RPend[p] = (r_cnt[w_ra] != '0);
`endif
   end

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed scoreboard bench for pipe_regfile_sb; expectations follow RF_BYPASS_EN.
module tb_pipe_regfile_sb;

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_PEND0 = 2, SEL_PEND1 = 3,
                  SEL_READY = 4, SEL_ERR = 5;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic [9:0]  RA;
   logic [63:0] RD;
   logic [1:0]  RPend;
   logic        WE3, Retire, IssueValid, IssueReady, Flush, SbErr;
   logic [4:0]  A3, IssueAddr, ra0, ra1;
   logic [31:0] WD3;

   int vectors = 0;
   int miscompares = 0;

   string       tagQ[$];
   int          selQ[$];
   logic [31:0] expQ[$];

   assign RA = {ra1, ra0};

   always #5 Clk = ~Clk;

   pipe_regfile_sb dut (
      .Clk(Clk), .Reset_n(Reset_n), .RA(RA), .RD(RD), .RPend(RPend),
      .WE3(WE3), .A3(A3), .WD3(WD3), .Retire(Retire),
      .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueReady(IssueReady),
      .Flush(Flush), .SbErr(SbErr)
   );

   function automatic logic [31:0] observe(int sel);
      case (sel)
         SEL_RD0:   return RD[31:0];
         SEL_RD1:   return RD[63:32];
         SEL_PEND0: return {31'd0, RPend[0]};
         SEL_PEND1: return {31'd0, RPend[1]};
         SEL_READY: return {31'd0, IssueReady};
         default:   return {31'd0, SbErr};
      endcase
   endfunction

   task automatic expectOut(input string tag, input int sel, input logic [31:0] value);
      tagQ.push_back(tag);
      selQ.push_back(sel);
      expQ.push_back(value);
   endtask

   task automatic checkOutput();
      string       tag;
      int          sel;
      logic [31:0] exp;
      logic [31:0] obs;
      #1;
      while (tagQ.size() > 0) begin
         tag = tagQ.pop_front();
         sel = selQ.pop_front();
         exp = expQ.pop_front();
         obs = observe(sel);
         vectors++;
         assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   task automatic applyStimulus(input logic we, input logic ret, input logic [4:0] a3,
                                input logic [31:0] wd, input logic iv, input logic [4:0] ia,
                                input logic fl, input logic [4:0] r0, input logic [4:0] r1);
      WE3 = we; Retire = ret; A3 = a3; WD3 = wd;
      IssueValid = iv; IssueAddr = ia; Flush = fl;
      ra0 = r0; ra1 = r1;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      expectOut("rst_rd0", SEL_RD0, 0);
      expectOut("rst_rd1", SEL_RD1, 0);
      expectOut("rst_pend0", SEL_PEND0, 0);
      expectOut("rst_pend1", SEL_PEND1, 0);
      expectOut("rst_ready", SEL_READY, 1);
      expectOut("rst_err", SEL_ERR, 0);
      checkOutput();
      Reset_n = 1'b1;
      tick();

      // Preload r5 with two pending issues and a stray retire, then reset mid-cycle
      applyStimulus(1, 0, 5, 32'h1234, 1, 5, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0);
      tick();
      applyStimulus(1, 1, 6, 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 5, 0, 5, 0);
      expectOut("pre_rd0", SEL_RD0, 32'h1234);
      expectOut("pre_pend0", SEL_PEND0, 1);
      expectOut("pre_err", SEL_ERR, 1);
      checkOutput();
      Reset_n = 1'b0;
      expectOut("midrst_rd0", SEL_RD0, 0);
      expectOut("midrst_pend0", SEL_PEND0, 0);
      expectOut("midrst_err", SEL_ERR, 0);
      expectOut("midrst_ready", SEL_READY, 1);
      checkOutput();
      #1 Reset_n = 1'b1;
      tick();

      // Write-through bypass on r7
      applyStimulus(1, 0, 7, 32'h11, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0);
      expectOut("byp_rd0", SEL_RD0, BYP ? 32'hDEADBEEF : 32'h11);
      checkOutput();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
      expectOut("byp_next_rd0", SEL_RD0, 32'hDEADBEEF);
      checkOutput();

      // Register 0 is hardwired
      applyStimulus(1, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
      expectOut("r0_rd0", SEL_RD0, 0);
      expectOut("r0_rd1", SEL_RD1, 0);
      expectOut("r0_pend0", SEL_PEND0, 0);
      expectOut("r0_pend1", SEL_PEND1, 0);
      expectOut("r0_ready", SEL_READY, 1);
      checkOutput();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      expectOut("r0_next_rd0", SEL_RD0, 0);
      expectOut("r0_next_pend0", SEL_PEND0, 0);
      checkOutput();

      // Saturate r3, drop a fourth issue, then retire+issue on the full counter
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 3, 0, 3, 0);
         expectOut("sat_ready_fill", SEL_READY, 1);
         checkOutput();
         tick();
      end
      expectOut("sat_ready_full", SEL_READY, 0);
      expectOut("sat_pend0", SEL_PEND0, 1);
      checkOutput();
      tick();
      applyStimulus(1, 1, 3, 32'h33, 1, 3, 0, 3, 0);
      expectOut("sat_ready_retire", SEL_READY, 1);
      expectOut("sat_pend_retire", SEL_PEND0, 1);
      checkOutput();
      tick();
      applyStimulus(0, 0, 0, 0, 1, 3, 0, 3, 0);
      expectOut("sat_ready_still_full", SEL_READY, 0);
      checkOutput();
      applyStimulus(1, 1, 3, 32'h33, 0, 0, 0, 3, 0);
      tick();
      expectOut("sat_ready_after_ret", SEL_READY, 1);
      checkOutput();
      tick();
      expectOut("sat_last_pend", SEL_PEND0, BYP ? 0 : 1);
      checkOutput();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 0);
      expectOut("sat_drained_pend", SEL_PEND0, 0);
      expectOut("sat_drained_err", SEL_ERR, 0);
      checkOutput();

      // Final retire of r9 on read port 1
      applyStimulus(0, 0, 0, 0, 1, 9, 0, 0, 9);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9);
      expectOut("fin_pend_before", SEL_PEND1, 1);
      checkOutput();
      applyStimulus(1, 1, 9, 32'h42, 0, 0, 0, 0, 9);
      expectOut("fin_pend_same", SEL_PEND1, BYP ? 0 : 1);
      expectOut("fin_rd1_same", SEL_RD1, BYP ? 32'h42 : 32'h0);
      checkOutput();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9);
      expectOut("fin_pend_next", SEL_PEND1, 0);
      expectOut("fin_rd1_next", SEL_RD1, 32'h42);
      checkOutput();

      // Flush beats a same-cycle issue; a later retire trips the error flag
      applyStimulus(0, 0, 0, 0, 1, 4, 0, 4, 0);
      tick();
      tick();
      applyStimulus(0, 0, 0, 0, 1, 4, 1, 4, 0);
      expectOut("fl_pend_before", SEL_PEND0, 1);
      checkOutput();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0);
      expectOut("fl_pend_after", SEL_PEND0, 0);
      checkOutput();
      applyStimulus(1, 1, 4, 32'h44, 0, 0, 0, 4, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 0);
      expectOut("fl_err", SEL_ERR, 1);
      expectOut("fl_pend_err", SEL_PEND0, 0);
      expectOut("fl_rd0", SEL_RD0, 32'h44);
      checkOutput();

      // Retire on an idle counter under Flush writes data but raises no error
      Reset_n = 1'b0;
      #2 Reset_n = 1'b1;
      applyStimulus(1, 1, 8, 32'h88, 0, 0, 1, 8, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 0);
      expectOut("flret_err", SEL_ERR, 0);
      expectOut("flret_rd0", SEL_RD0, 32'h88);
      checkOutput();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
